delay: RTL and testbench
========================

// Module: delay
// PURPOSE
//  Programmable millisecond delay timer for the voltmeter control path.
//  While enabled, divides clk by mod to form 1 ms ticks and counts delay_ms ticks.
//  Emits a one-cycle finish pulse when the programmed interval elapses, then
//  automatically starts the next interval.
//  Sequencers use it to pace ADC sampling and display refresh.
// PARAMETERS
//  mbits  4       width of delay_ms and of the internal ms counter
//  mod    100000  clk cycles per millisecond (100 MHz clk); must be >= 2
// PORTS
//  clk       in   1      system clock, rising-edge
//  rst       in   1      reset: asynchronous, active-low
//  en        in   1      count enable; low = idle/clear
//  delay_ms  in   mbits  interval length in ms (0 treated as 1)
//  finish    out  1      one-cycle pulse at end of each interval
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, prescaler=0, ms_cnt=0, len=0, finish=0.
//  - Prescaler: width $clog2(mod).
//    - Increments on each rising edge with en=1 and state!=IDLE->entry.
//    - Wraps mod-1 -> 0 and raises tick for that edge.
//  - ms_cnt: mbits wide; increments on tick.
//  - Terminal: a tick with ms_cnt==len-1 ends the interval (no overflow possible).
//  - States:
//    - IDLE: counters cleared, finish=0.
//      - en=1 -> latch len = (delay_ms==0 ? 1 : delay_ms); go to COUNT.
//      - The latching edge is enabled edge #1 and already advances the prescaler.
//    - COUNT: count per the prescaler/ms_cnt rules above.
//      - On terminal edge: finish<=1; clear prescaler and ms_cnt.
//      - On terminal edge: re-latch len from delay_ms; stay in COUNT.
//      - en=0 -> IDLE (counters cleared, finish<=0).
//  - Latency: finish is registered.
//    - It is high for exactly the one cycle following the (len*mod)-th consecutive enabled edge.
//    - Period between pulses with en held high = len*mod cycles.
//  - delay_ms changes mid-interval are ignored until the next re-latch.
//  - en=0 on the edge that would be terminal: en wins, no finish, go IDLE.
//  - en re-asserted after any low period restarts a full interval from zero.
//  - finish never asserts while en=0 is sampled or during/after reset.
//  - mid-operation rst: immediate clear; first interval after release is full length.
// STRUCTURE
//  - Shared package delay_pkg: state encoding constants (IDLE, COUNT).
//  - Shared package delay_pkg: DLY_DEFAULT_MOD=100000.
//  - One sub-module ms_prescaler (params mod; ports clk, rst, clr, en, tick).
//  - Top holds the FSM, len register, ms_cnt and finish register.
// TESTING  (bench uses mod=10, mbits=4, 10 ns clk)
//  - Reset: pulse rst=0 mid-cycle -> finish=0 immediately.
//    - After release with en=0: no pulse for 200 cycles.
//  - en=1, delay_ms=1 held: first finish pulse after 10th enabled edge, width 1 cycle.
//    - Following pulses every 10 cycles.
//  - delay_ms=3: pulse after 30 enabled edges.
//    - Change delay_ms to 5 at edge 12 -> current pulse still at 30; next at +50.
//  - en low at edge 15 of 30 for 4 cycles, then high: next finish 30 edges after re-raise.
//  - Bench drops en on each finish, waits 4 clk, re-raises: pulses spaced len*mod+5 cycles.
//  - delay_ms=0: identical timing to delay_ms=1 (pulse every 10 cycles).
//  - rst=0 at edge 20 of 30: finish stays 0.
//    - After release with en=1, pulse after 30 enabled edges.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared definitions for the millisecond delay timer: FSM state encoding,
// default parameter values and the prescaler width helper.
package delay_pkg;

    // Timer FSM: IDLE holds everything cleared, COUNT paces intervals.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // 100 MHz system clock -> 100000 cycles per millisecond.
    localparam int DLY_DEFAULT_MOD   = 100000;
    localparam int DLY_DEFAULT_MBITS = 4;

    // Width of a counter that must hold 0 .. m-1; never narrower than 1 bit.
    function automatic int presc_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage : delay_pkg

// File: rtl/ms_prescaler.sv
// Divides clk by mod while enabled. tick is high on the edge where the
// counter wraps from mod-1 back to 0, i.e. once every mod enabled edges.
module ms_prescaler
    import delay_pkg::*;
#(
    parameter int mod = DLY_DEFAULT_MOD
) (
    input  logic clk,
    input  logic rst,   // asynchronous, active-low
    input  logic clr,   // synchronous return to zero, wins over en
    input  logic en,
    output logic tick
);

    localparam int              W    = presc_width(mod);
    localparam logic [W-1:0]    LAST = W'(mod - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next-count and wrap detection.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Prescaler count register.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order processes are evaluated in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : ms_prescaler

// File: rtl/delay.sv
// Programmable millisecond delay timer. While en is high it counts len ms
// (len latched from delay_ms, 0 meaning 1) and pulses finish for one cycle at
// the end of each interval, then immediately starts the next one. Dropping en
// abandons the interval; raising it again starts a fresh full interval.
module delay
    import delay_pkg::*;
#(
    parameter int mbits = DLY_DEFAULT_MBITS,
    parameter int mod   = DLY_DEFAULT_MOD
) (
    input  logic             clk,
    input  logic             rst,       // asynchronous, active-low
    input  logic             en,
    input  logic [mbits-1:0] delay_ms,
    output logic             finish
);

    state_t           state_q;
    state_t           state_d;
    logic [mbits-1:0] len_q;
    logic [mbits-1:0] len_d;
    logic [mbits-1:0] ms_cnt_q;
    logic [mbits-1:0] ms_cnt_d;
    logic             finish_q;
    logic             finish_d;

    logic             tick;
    logic             terminal;
    logic [mbits-1:0] delay_eff;

    // The prescaler runs on every enabled edge, including the IDLE->COUNT
    // latching edge, and is held at zero whenever en is low. The terminal edge
    // needs no explicit clear: it is always a wrap edge, so the count is
    // already returning to zero.
    ms_prescaler #(
        .mod (mod)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (!en),
        .en   (en),
        .tick (tick)
    );

    // Interval length to latch and end-of-interval detection. len is never 0
    // once latched, so len-1 cannot underflow and ms_cnt never overflows.
    always_comb begin
        delay_eff = (delay_ms == '0) ? mbits'(1) : delay_ms;
        terminal  = (state_q == COUNT) && en && tick &&
                    (ms_cnt_q == (len_q - mbits'(1)));
    end

    // FSM next state, length latch, ms counter and finish pulse.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ms_cnt_d = ms_cnt_q;
        finish_d = 1'b0;
        case (state_q)
            IDLE: begin
                ms_cnt_d = '0;
                if (en) begin
                    len_d   = delay_eff;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    // en wins even on what would have been the terminal edge.
                    ms_cnt_d = '0;
                    state_d  = IDLE;
                end else if (terminal) begin
                    // Pulse, restart counting and pick up any new length.
                    finish_d = 1'b1;
                    ms_cnt_d = '0;
                    len_d    = delay_eff;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + mbits'(1);
                end
            end
            default: begin
                ms_cnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State, length, ms counter and registered finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            ms_cnt_q <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            ms_cnt_q <= ms_cnt_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;

endmodule : delay

// File: tb/tb_delay.sv
// Directed bench for the delay timer with mod=10, mbits=4 and a 10 ns clock.
// Inputs change and outputs are sampled on the falling edge.
module tb_delay;

    localparam int MBITS = 4;
    localparam int MOD   = 10;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic [MBITS-1:0] delay_ms = '0;
    logic             finish;

    int checks   = 0;
    int failures = 0;
    int n;
    int p;

    delay #(
        .mbits (MBITS),
        .mod   (MOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .delay_ms (delay_ms),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance k clock edges, counting samples where finish was not low.
    task automatic step(input int k, output int pulses);
        pulses = 0;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
            if (finish !== 1'b0) pulses++;
        end
    endtask

    // Number of edges until finish is seen high (-1 if the bound expires).
    task automatic wait_finish(input int max, output int edges);
        bit done;
        done  = 1'b0;
        edges = -1;
        for (int i = 1; i <= max && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (finish === 1'b1) begin
                edges = i;
                done  = 1'b1;
            end
        end
    endtask

    initial begin
        // Reset asserted mid-cycle clears finish at once; idle stays silent.
        #2 rst = 1'b0;
        #1 check("reset_async", finish, 0);
        @(negedge clk);
        rst = 1'b1;
        step(200, p);
        check("idle_no_pulse", p, 0);

        // delay_ms=1: pulse after 10 enabled edges, then every 10, 1 cycle wide.
        delay_ms = 4'd1;
        en       = 1'b1;
        wait_finish(100, n);
        check("ms1_first", n, 10);
        wait_finish(100, n);
        check("ms1_second", n, 10);
        wait_finish(100, n);
        check("ms1_third", n, 10);
        step(1, p);
        check("ms1_width", p, 0);
        en = 1'b0;
        step(3, p);
        check("ms1_idle", p, 0);

        // delay_ms=3 with a change to 5 at edge 12: 30 then 50.
        delay_ms = 4'd3;
        en       = 1'b1;
        step(12, p);
        check("ms3_early", p, 0);
        delay_ms = 4'd5;
        wait_finish(100, n);
        check("ms3_rest", n, 18);
        wait_finish(100, n);
        check("ms5_relatch", n, 50);
        en = 1'b0;
        step(3, p);
        check("ms5_idle", p, 0);

        // en low at edge 15 for 4 cycles: full 30 edges after re-raise.
        delay_ms = 4'd3;
        en       = 1'b1;
        step(15, p);
        check("gap_before", p, 0);
        en = 1'b0;
        step(4, p);
        check("gap_low", p, 0);
        en = 1'b1;
        wait_finish(100, n);
        check("gap_restart", n, 30);

        // Drop en after each pulse, wait 4 clk, re-raise: spacing len*mod+5.
        step(1, p);
        check("drop3_width", p, 0);
        en = 1'b0;
        step(4, p);
        en = 1'b1;
        wait_finish(100, n);
        check("drop3_spacing", n + 5, 35);
        step(1, p);
        en       = 1'b0;
        delay_ms = 4'd1;
        step(4, p);
        en = 1'b1;
        wait_finish(100, n);
        check("drop1_spacing", n + 5, 15);

        // delay_ms=0 behaves as 1.
        en = 1'b0;
        step(3, p);
        delay_ms = 4'd0;
        en       = 1'b1;
        wait_finish(100, n);
        check("ms0_first", n, 10);
        wait_finish(100, n);
        check("ms0_second", n, 10);

        // Reset during a pulse kills it immediately.
        #2 rst = 1'b0;
        #1 check("reset_mid_pulse", finish, 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(2, p);
        check("post_reset_idle", p, 0);

        // Reset at edge 20 of 30: no pulse; full interval after release.
        delay_ms = 4'd3;
        en       = 1'b1;
        step(20, p);
        check("rst20_before", p, 0);
        #2 rst = 1'b0;
        #1 check("rst20_async", finish, 0);
        step(3, p);
        check("rst20_held", p, 0);
        rst = 1'b1;
        wait_finish(100, n);
        check("rst20_full", n, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_delay
